// File: rtl/aes_dec_pkg.sv
// Shared types and column-routing helpers for the AES decryption datapath.
// A state is four 32-bit columns, with column 0 in the most significant word.
package aes_dec_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_COL_W   = 32;
   localparam int AES_NCOL    = AES_STATE_W / AES_COL_W;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // Index of the least significant bit of column idx.
   function automatic logic [6:0] colBase(input int idx);
      return 7'(AES_COL_W * (AES_NCOL - 1 - idx));
   endfunction

   function automatic logic [AES_COL_W-1:0] colSel(input logic [AES_STATE_W-1:0] s, input int idx);
      return s[colBase(idx) +: AES_COL_W];
   endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Input and output valid/ready streams of the InvMixColumns engine.
// The master drives states in and accepts results; the slave is the engine.
interface inv_mix_columns_seq_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_bypass;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, in_bypass, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_bypass, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/inv_mix_columns_seq_helper.sv
// Combinational InvMixColumns on a single column.
// Byte 0 of the column is in the MSB.
module MixColumnHelper (
   input  logic [31:0] i_col,
   output logic [31:0] o_col
);

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Each multiplier is built as a chain of doublings, for example 14 = ((2 + 1) * 2 + 1) * 2.
   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] b);
      return xt(xt(xt(b)) ^ b) ^ b;
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] b);
      return xt(xt(xt(b) ^ b)) ^ b;
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] b);
      return xt(xt(xt(b) ^ b) ^ b);
   endfunction

   logic [7:0] w_a0, w_a1, w_a2, w_a3;

   assign {w_a0, w_a1, w_a2, w_a3} = i_col;

   assign o_col[31:24] = mul14(w_a0) ^ mul11(w_a1) ^ mul13(w_a2) ^ mul9(w_a3);
   assign o_col[23:16] = mul9(w_a0)  ^ mul14(w_a1) ^ mul11(w_a2) ^ mul13(w_a3);
   assign o_col[15:8]  = mul13(w_a0) ^ mul9(w_a1)  ^ mul14(w_a2) ^ mul11(w_a3);
   assign o_col[7:0]   = mul11(w_a0) ^ mul13(w_a1) ^ mul9(w_a2)  ^ mul14(w_a3);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns engine. It transforms COLS_PER_CYCLE columns per cycle in place
// and has a bypass path for the final decryption round.
module inv_mix_columns_seq
   import aes_dec_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   inv_mix_columns_seq_if.slave  bus,
   input  logic                  abort,
   output logic                  busy
);

   localparam int         NCYC     = AES_NCOL / COLS_PER_CYCLE;
   localparam logic [1:0] LAST_CNT = 2'(NCYC - 1);

   state_t                 r_state;
   logic [1:0]             r_colCnt;
   logic [AES_STATE_W-1:0] r_work;
   logic [AES_STATE_W-1:0] r_outData;
   logic                   r_outValid;

   logic [AES_COL_W-1:0]   w_helperIn  [COLS_PER_CYCLE];
   logic [AES_COL_W-1:0]   w_helperOut [COLS_PER_CYCLE];
   logic [AES_STATE_W-1:0] w_workNext;

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gHelper
      assign w_helperIn[g] = colSel(r_work, int'(r_colCnt) * COLS_PER_CYCLE + g);
      MixColumnHelper uHelper (
         .i_col (w_helperIn[g]),
         .o_col (w_helperOut[g])
      );
   end

   // Write the helper results back into their own column slots. All other columns keep their values.
   always_comb begin
      w_workNext = r_work;
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
         w_workNext[colBase(int'(r_colCnt) * COLS_PER_CYCLE + g) +: AES_COL_W] = w_helperOut[g];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_colCnt   <= 2'd0;
         r_work     <= '0;
         r_outData  <= '0;
         r_outValid <= 1'b0;
      end else if (abort) begin
         r_state    <= IDLE;
         r_colCnt   <= 2'd0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_work   <= bus.in_data;
                  r_colCnt <= 2'd0;
                  if (bus.in_bypass) begin
                     r_state    <= DONE;
                     r_outData  <= bus.in_data;
                     r_outValid <= 1'b1;
                  end else begin
                     r_state <= BUSY;
                  end
               end
            end
            // The last pass publishes its result directly, so out_valid rises on the same edge the FSM enters DONE.
            BUSY: begin
               r_work <= w_workNext;
               if (r_colCnt == LAST_CNT) begin
                  r_state    <= DONE;
                  r_colCnt   <= 2'd0;
                  r_outData  <= w_workNext;
                  r_outValid <= 1'b1;
               end else begin
                  r_colCnt <= r_colCnt + 2'd1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state    <= IDLE;
                  r_outValid <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_outValid;
   assign bus.out_data  = r_outData;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq. The main instance uses COLS_PER_CYCLE=1;
// the 2-column and 4-column instances are used only for the latency check.
module tb_inv_mix_columns_seq;

   localparam int CPC  = 1;
   localparam int NCYC = 4 / CPC;

   typedef struct {
      logic [127:0] data;
      logic         bypass;
      logic [127:0] mask;
      logic [127:0] expData;
   } vec_t;

   logic clk;
   logic rst_n;
   logic abort;
   logic busy, busy2, busy4;
   int   checks;
   int   errors;

   inv_mix_columns_seq_if busIf ();
   inv_mix_columns_seq_if busIf2 ();
   inv_mix_columns_seq_if busIf4 ();

   inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
      .clk (clk), .rst_n (rst_n), .bus (busIf), .abort (abort), .busy (busy)
   );
   inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
      .clk (clk), .rst_n (rst_n), .bus (busIf2), .abort (1'b0), .busy (busy2)
   );
   inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
      .clk (clk), .rst_n (rst_n), .bus (busIf4), .abort (1'b0), .busy (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] invCol(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9),
              gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13),
              gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11),
              gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14)};
   endfunction

   function automatic logic [127:0] invMix(input logic [127:0] s);
      return {invCol(s[127:96]), invCol(s[95:64]), invCol(s[63:32]), invCol(s[31:0])};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic [127:0] data, input logic bypass);
      bit ready = 1'b0;
      for (int i = 0; i < 50 && !ready; i++) begin
         @(negedge clk);
         ready = busIf.in_ready;
      end
      if (!ready) checkOutput("in_ready timeout", 128'(busIf.in_ready), 128'd1);
      busIf.in_valid  = 1'b1;
      busIf.in_data   = data;
      busIf.in_bypass = bypass;
      @(posedge clk);
      #1;
      busIf.in_valid  = 1'b0;
      busIf.in_bypass = 1'b0;
   endtask

   // Returns #1 after the first edge at which out_valid is high. lat is 1 when the accepting edge itself raised it.
   task automatic waitOutput(output logic [127:0] data, output int lat);
      lat = 1;
      while (!busIf.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!busIf.out_valid) checkOutput("out_valid timeout", 128'(busIf.out_valid), 128'd1);
      data = busIf.out_data;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached before finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t         vecs [6];
      logic [127:0] got;
      int           lat;
      int           lat2, lat4;
      logic [127:0] got2, got4;
      logic [127:0] tp [4];
      logic [127:0] outDat [4];
      int           outCyc [4];
      int           acc, nOut, extra, seen;
      bit           accNow;

      checks = 0;
      errors = 0;
      vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, {128{1'b1}},
                  128'hdb135345_f20a225c_01010101_c6c6c6c6};
      vecs[1] = '{128'h4d7ebdf8_d5d5d7d6_00112233_44556677, 1'b1, {128{1'b1}},
                  128'h4d7ebdf8_d5d5d7d6_00112233_44556677};
      vecs[2] = '{128'h4d7ebdf8_d5d5d7d6_00112233_44556677, 1'b0, {{64{1'b1}}, 64'h0},
                  128'h2d26314c_d4d4d4d5_00000000_00000000};
      vecs[3] = '{128'h0, 1'b0, {128{1'b1}}, 128'h0};
      vecs[4] = '{128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc, 1'b0, {128{1'b1}},
                  128'hc6c6c6c6_01010101_f20a225c_db135345};
      vecs[5] = '{128'hffffffff_00000000_d5d5d7d6_4d7ebdf8, 1'b0, {128{1'b1}},
                  128'hffffffff_00000000_d4d4d4d5_2d26314c};

      rst_n = 1'b0;
      abort = 1'b0;
      busIf.in_valid = 1'b0;  busIf.in_data = '0;  busIf.in_bypass = 1'b0;  busIf.out_ready = 1'b1;
      busIf2.in_valid = 1'b0; busIf2.in_data = '0; busIf2.in_bypass = 1'b0; busIf2.out_ready = 1'b1;
      busIf4.in_valid = 1'b0; busIf4.in_data = '0; busIf4.in_bypass = 1'b0; busIf4.out_ready = 1'b1;
      #1;
      checkOutput("reset in_ready", 128'(busIf.in_ready), 128'd1);
      checkOutput("reset out_valid", 128'(busIf.out_valid), 128'd0);
      checkOutput("reset out_data", busIf.out_data, 128'h0);
      checkOutput("reset busy", 128'(busy), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].data, vecs[i].bypass);
         waitOutput(got, lat);
         checkOutput($sformatf("vec%0d data", i), got & vecs[i].mask, vecs[i].expData);
         checkOutput($sformatf("vec%0d latency", i), 128'(lat), vecs[i].bypass ? 128'd1 : 128'(NCYC + 1));
         @(posedge clk);
         #1;
      end

      // Latency of the 2-column and 4-column instances, which accept on the same edge.
      @(negedge clk);
      busIf2.in_valid = 1'b1; busIf2.in_data = vecs[0].data;
      busIf4.in_valid = 1'b1; busIf4.in_data = vecs[0].data;
      @(posedge clk);
      #1;
      busIf2.in_valid = 1'b0;
      busIf4.in_valid = 1'b0;
      lat2 = 0; lat4 = 0; got2 = '0; got4 = '0;
      for (int c = 1; c <= 8; c++) begin
         if (busIf2.out_valid && lat2 == 0) begin lat2 = c; got2 = busIf2.out_data; end
         if (busIf4.out_valid && lat4 == 0) begin lat4 = c; got4 = busIf4.out_data; end
         @(posedge clk);
         #1;
      end
      checkOutput("cpc2 latency", 128'(lat2), 128'd3);
      checkOutput("cpc4 latency", 128'(lat4), 128'd2);
      checkOutput("cpc2 data", got2, vecs[0].expData);
      checkOutput("cpc4 data", got4, vecs[0].expData);

      // Backpressure: the result must hold while DONE ignores further in_valid pulses.
      busIf.out_ready = 1'b0;
      applyStimulus(vecs[0].data, 1'b0);
      waitOutput(got, lat);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         busIf.in_valid = c[0];
         busIf.in_data  = 128'h11111111_22222222_33333333_44444444;
         checkOutput("hold out_valid", 128'(busIf.out_valid), 128'd1);
         checkOutput("hold out_data", busIf.out_data, vecs[0].expData);
         checkOutput("hold in_ready", 128'(busIf.in_ready), 128'd0);
      end
      @(negedge clk);
      busIf.in_valid  = 1'b0;
      busIf.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("release in_ready", 128'(busIf.in_ready), 128'd1);
      checkOutput("release out_valid", 128'(busIf.out_valid), 128'd0);
      checkOutput("release busy", 128'(busy), 128'd0);

      // Abort in the second BUSY cycle.
      applyStimulus(vecs[0].data, 1'b0);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("abort busy", 128'(busy), 128'd0);
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         if (busIf.out_valid) seen++;
         @(posedge clk);
         #1;
      end
      checkOutput("abort no out_valid", 128'(seen), 128'd0);
      applyStimulus(vecs[4].data, 1'b0);
      waitOutput(got, lat);
      checkOutput("after abort data", got, vecs[4].expData);
      @(posedge clk);
      #1;

      // An abort coinciding with in_valid must win.
      @(negedge clk);
      busIf.in_valid = 1'b1;
      busIf.in_data  = vecs[0].data;
      abort = 1'b1;
      @(posedge clk);
      #1;
      busIf.in_valid = 1'b0;
      abort = 1'b0;
      checkOutput("abort+valid busy", 128'(busy), 128'd0);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (busIf.out_valid) seen++;
         @(posedge clk);
         #1;
      end
      checkOutput("abort+valid no output", 128'(seen), 128'd0);

      // An abort coinciding with out_ready in DONE: the result is withdrawn.
      busIf.out_ready = 1'b0;
      applyStimulus(vecs[0].data, 1'b0);
      waitOutput(got, lat);
      @(negedge clk);
      abort = 1'b1;
      busIf.out_ready = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("abort in DONE out_valid", 128'(busIf.out_valid), 128'd0);
      checkOutput("abort in DONE busy", 128'(busy), 128'd0);

      // Asynchronous reset, first in BUSY and then in DONE, asserted between clock edges.
      applyStimulus(vecs[0].data, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset busy", 128'(busy), 128'd0);
      checkOutput("async reset in_ready", 128'(busIf.in_ready), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      busIf.out_ready = 1'b0;
      applyStimulus(vecs[5].data, 1'b0);
      waitOutput(got, lat);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset DONE out_valid", 128'(busIf.out_valid), 128'd0);
      checkOutput("async reset DONE out_data", busIf.out_data, 128'h0);
      checkOutput("async reset DONE busy", 128'(busy), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      busIf.out_ready = 1'b1;

      for (int i = 0; i < 8; i++) begin
         logic [127:0] r;
         r = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(r, 1'b0);
         waitOutput(got, lat);
         checkOutput($sformatf("random%0d data", i), got, invMix(r));
         @(posedge clk);
         #1;
      end

      // Back-to-back stream with in_valid and out_ready held high.
      tp[0] = 128'h01234567_89abcdef_fedcba98_76543210;
      tp[1] = vecs[0].data;
      tp[2] = 128'hdeadbeef_cafef00d_0badc0de_12345678;
      tp[3] = vecs[5].data;
      acc = 0;
      nOut = 0;
      for (int cyc = 0; cyc < 80 && nOut < 4; cyc++) begin
         @(negedge clk);
         if (busIf.out_valid) begin
            outDat[nOut] = busIf.out_data;
            outCyc[nOut] = cyc;
            nOut++;
         end
         busIf.in_valid = (acc < 4);
         busIf.in_data  = tp[(acc < 4) ? acc : 3];
         accNow = busIf.in_ready && (acc < 4);
         @(posedge clk);
         if (accNow) acc++;
      end
      busIf.in_valid = 1'b0;
      checkOutput("stream count", 128'(nOut), 128'd4);
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busIf.out_valid) extra++;
      end
      checkOutput("stream no duplicates", 128'(extra), 128'd0);
      for (int k = 0; k < 4 && k < nOut; k++) begin
         checkOutput($sformatf("stream%0d data", k), outDat[k], invMix(tp[k]));
         if (k > 0) checkOutput($sformatf("stream%0d spacing", k), 128'(outCyc[k] - outCyc[k-1]), 128'(NCYC + 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Sequential InvMixColumns engine for the AES-256 decryption round datapath. Accepts one 128-bit state with a valid/ready handshake and applies InvMixColumns column by column, reusing COLS_PER_CYCLE column-helper instances. It returns the result with a valid/ready handshake. The round controller sits upstream; AddRoundKey for the next round sits downstream. A bypass input lets the final decryption round skip the transform while keeping the same handshake.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per cycle; legal values 1, 2, 4; number of helper instances equals this value
NCYC (localparam), 4/COLS_PER_CYCLE, processing cycles per state

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input state valid
in_ready  out  1  engine can accept a state
in_data  in  128  state; column 0 = [127:96], column 3 = [31:0]; byte 0 of each column in the MSB
in_bypass  in  1  sampled with in_data; 1 = pass the state through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  128  result state, same column layout as in_data
abort  in  1  synchronous flush, highest priority after reset
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, col_cnt=0, work register=0, out_valid=0, out_data=0, busy=0. in_ready follows state, so it reads 1 during reset. Inputs are ignored while rst_n is low.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_data into the work register and clear col_cnt.
  - If in_bypass=1, go to DONE. Otherwise go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, columns col_cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 pass through the helpers and the results are written back in place.
  - col_cnt increments each cycle. When col_cnt==NCYC-1, go to DONE.
- DONE:
  - out_valid=1 and out_data=work register, both held stable until out_ready.
  - On out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- Latency, measured from the accepting edge to the first cycle out_valid=1:
  - Transform: NCYC+1 cycles (5 cycles at COLS_PER_CYCLE=1, 2 at 4).
  - Bypass: 1 cycle.
- Throughput: one state per NCYC+2 cycles with out_ready tied high.
- abort=1 in any state: next cycle state=IDLE, out_valid=0, col_cnt=0. Any partial result is discarded and the work register is not cleared.
  - abort and an in_valid handshake in the same cycle: abort wins and nothing is accepted.
  - abort and out_ready in DONE in the same cycle: that result counts as not delivered.
- out_data is registered only, with no combinational path from in_data.
- out_valid never drops without either an out_ready handshake or abort.
- GF(2^8) arithmetic lives entirely inside the helper. The engine performs only byte/column routing.
- col_cnt width is 2 bits. It must not wrap past NCYC-1 while in BUSY.
- Reset asserted mid-operation returns all outputs to reset values immediately.

Decomposition:
- Shared package aes_dec_pkg:
  - state enum {IDLE, BUSY, DONE}
  - AES_STATE_W=128, AES_COL_W=32
  - column-select helper function (column index to bit slice)
- Sub-module: the existing inverse column helper MixColumnHelper (32-bit in, 32-bit out, combinational), instantiated COLS_PER_CYCLE times in a generate loop. No other sub-modules.

Test Plan:
1. FIPS-197 columns: in_data=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, bypass=0, out_ready=1 → out_data=128'hdb135345_f20a225c_01010101_c6c6c6c6, out_valid rising exactly 5 cycles after accept (COLS_PER_CYCLE=1); repeat at COLS_PER_CYCLE=2 and 4 → 3 and 2 cycles.
2. Bypass: in_data=128'h4d7ebdf8_d5d5d7d6_00112233_44556677, bypass=1 → identical out_data 1 cycle after accept; then bypass=0 with the same input → 128'h2d26314c_d4d4d4d5_… (first two columns checked).
3. Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and out_data stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 → in_ready=1 next cycle.
4. Abort: abort in the 2nd BUSY cycle → IDLE next cycle, out_valid never asserts; a following state completes correctly. Abort coinciding with in_valid → no accept.
5. Async reset: pull rst_n low mid-BUSY and between clock edges → out_valid=0, busy=0, out_data=0 immediately; after release, a back-to-back stream of 8 random states matches a reference-model InvMixColumns.
6. Back-to-back throughput: in_valid and out_ready held high with 4 states → results in order at one per NCYC+2 cycles, with no drops or duplicates.
